// File: rtl/iob_axis_framer_if.sv
// AXI-Stream bundle for iob_axis_framer. The raw input side carries no tlast,
// so the slave modport leaves it out.
interface iob_axis_framer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/iob_axis_framer.sv
// Adds tlast to a raw word stream, either by word count or by idle timeout.
// Define IOB_AXIS_FRAMER_TIMEOUT_EN to compile in the idle counter and timeout flush.
module iob_axis_framer #(
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 10,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 cke_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [LEN_W-1:0]     nwords_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    iob_axis_framer_if.slave     s_axis,
    iob_axis_framer_if.master    m_axis,
    output logic                 frame_done_o,
    output logic [LEN_W-1:0]     word_cnt_o
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_h_data;
    logic [DATA_W-1:0] r_o_data;
    logic              r_o_valid;
    logic              r_o_last;
    logic              r_frame_done;
    logic [LEN_W-1:0]  r_word_cnt;

    logic w_h_v;
    logic w_o_free;
    logic w_s_tready;
    logic w_in_hs;
    logic w_final;
    logic w_to_hit;
    logic w_xfer;
    logic w_xfer_last;

    assign w_h_v      = (r_state != ST_EMPTY);
    assign w_o_free   = !r_o_valid || m_axis.tready;
    assign w_s_tready = en_i && !rst_i && (!w_h_v || w_o_free);
    assign w_in_hs    = s_axis.tvalid && w_s_tready;
    assign w_final    = (nwords_i != '0) && (r_word_cnt == nwords_i - LEN_W'(1));

`ifdef IOB_AXIS_FRAMER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_idle_cnt;

    // Timeout condition without the O-free term; the FSM applies that term.
    assign w_to_hit = (timeout_i != '0) && w_h_v && (r_idle_cnt >= timeout_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idle_cnt <= '0;
        end else if (cke_i) begin
            if (!w_h_v || w_in_hs) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != '1) begin
                r_idle_cnt <= r_idle_cnt + TIMEOUT_W'(1);
            end
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^timeout_i;
    assign w_to_hit         = 1'b0;
`endif

    // NOTE: every signal gets a default before the case, so no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = 1'b0;
        w_xfer_last = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_hs) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD, ST_FLUSH: begin
                w_xfer_last = w_final || w_to_hit || (r_state == ST_FLUSH);
                w_xfer      = w_o_free && (w_xfer_last || w_in_hs);
                if (w_xfer) begin
                    w_state_nxt = w_in_hs ? ST_HOLD : ST_EMPTY;
                end else if (w_xfer_last) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_EMPTY;
            r_o_valid    <= 1'b0;
            r_o_last     <= 1'b0;
            r_o_data     <= '0;
            r_word_cnt   <= '0;
            r_frame_done <= 1'b0;
        end else if (cke_i) begin
            r_state      <= w_state_nxt;
            r_frame_done <= r_o_valid && m_axis.tready && r_o_last;
            if (w_xfer) begin
                r_o_valid  <= 1'b1;
                r_o_data   <= r_h_data;
                r_o_last   <= w_xfer_last;
                r_word_cnt <= w_xfer_last ? '0 : r_word_cnt + LEN_W'(1);
            end else if (m_axis.tready) begin
                r_o_valid <= 1'b0;
                r_o_last  <= 1'b0;
            end
        end
    end

    // NOTE: H data needs no reset; the state register says whether it is meaningful.
    always_ff @(posedge clk_i) begin
        if (cke_i && w_in_hs) begin
            r_h_data <= s_axis.tdata;
        end
    end

    assign s_axis.tready = w_s_tready;
    assign m_axis.tdata  = r_o_data;
    assign m_axis.tvalid = r_o_valid;
    assign m_axis.tlast  = r_o_last;
    assign frame_done_o  = r_frame_done;
    assign word_cnt_o    = r_word_cnt;
endmodule

// File: tb/tb_iob_axis_framer.sv
// Directed bench for iob_axis_framer: count framing, timeout flush, single-word frames,
// backpressure, reset mid-frame and a 256-word loopback into a sink model.
module tb_iob_axis_framer;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 10;
    localparam int TIMEOUT_W = 16;

    logic                 clk = 1'b0;
    logic                 cke;
    logic                 rst;
    logic                 en;
    logic [LEN_W-1:0]     nwords;
    logic [TIMEOUT_W-1:0] timeout;
    logic                 frame_done;
    logic [LEN_W-1:0]     word_cnt;

    iob_axis_framer_if #(.DATA_W(DATA_W)) s_if ();
    iob_axis_framer_if #(.DATA_W(DATA_W)) m_if ();

    iob_axis_framer #(
        .DATA_W   (DATA_W),
        .LEN_W    (LEN_W),
        .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk_i       (clk),
        .cke_i       (cke),
        .rst_i       (rst),
        .en_i        (en),
        .nwords_i    (nwords),
        .timeout_i   (timeout),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .frame_done_o(frame_done),
        .word_cnt_o  (word_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_done   = 0;

    logic [DATA_W-1:0] out_data[$];
    bit                out_last[$];
    int                out_cyc[$];
    int                in_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Sink model standing in for the AXI-Stream input peripheral; samples mid-cycle.
    always @(negedge clk) begin
        if (!rst && m_if.tvalid && m_if.tready) begin
            out_data.push_back(m_if.tdata);
            out_last.push_back(m_if.tlast);
            out_cyc.push_back(cyc);
        end
        if (s_if.tvalid && s_if.tready) in_cyc.push_back(cyc);
        if (!rst && frame_done) n_done++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        out_data.delete();
        out_last.delete();
        out_cyc.delete();
        in_cyc.delete();
        n_done = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        int budget;
        budget      = 50;
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        while (!s_if.tready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("push_accepted", s_if.tready, 1'b1);
        step(1);
    endtask

    function automatic int data_errors(input int n, input int base);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= out_data.size() || out_data[i] !== DATA_W'(base + i)) e++;
        end
        return e;
    endfunction

    function automatic logic [63:0] last_mask(input int n);
        logic [63:0] m = '0;
        for (int i = 0; i < n && i < out_last.size(); i++) m[i] = out_last[i];
        return m;
    endfunction

    initial begin
        int d;
        int n_ready;
        int n_last;

        cke          = 1'b1;
        rst          = 1'b1;
        en           = 1'b1;
        nwords       = LEN_W'(4);
        timeout      = '0;
        s_if.tvalid  = 1'b0;
        s_if.tdata   = '0;
        s_if.tlast   = 1'b0;
        m_if.tready  = 1'b1;
        step(2);

        // Reset state while rst is still high
        check("rst_s_tready", s_if.tready, 1'b0);
        check("rst_m_tvalid", m_if.tvalid, 1'b0);
        check("rst_m_tlast", m_if.tlast, 1'b0);
        check("rst_m_tdata", m_if.tdata, '0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_word_cnt", word_cnt, '0);
        rst = 1'b0;
        #1;
        check("idle_s_tready", s_if.tready, 1'b1);
        clear_log();

        // Count framing: nwords=4, eight back-to-back words
        for (int i = 0; i < 8; i++) push_word(DATA_W'(i));
        s_if.tvalid = 1'b0;
        step(5);
        check("cnt4_out_words", out_data.size(), 8);
        check("cnt4_data", data_errors(8, 0), 0);
        check("cnt4_tlast_mask", last_mask(8), 64'h88);
        check("cnt4_input_b2b", in_cyc[7] - in_cyc[0], 7);
        check("cnt4_no_bubbles", out_cyc[7] - out_cyc[0], 7);
        check("cnt4_frame_done", n_done, 2);
        check("cnt4_word_cnt", word_cnt, '0);

        // Idle timeout: nwords=256, timeout=20, five words then idle
        do_reset();
        nwords  = LEN_W'(256);
        timeout = TIMEOUT_W'(20);
        for (int i = 0; i < 5; i++) push_word(DATA_W'(100 + i));
        s_if.tvalid = 1'b0;
        step(30);
`ifdef IOB_AXIS_FRAMER_TIMEOUT_EN
        check("to_out_words", out_data.size(), 5);
        check("to_data", data_errors(5, 100), 0);
        check("to_tlast_mask", last_mask(5), 64'h10);
        d = out_cyc[4] - in_cyc[4];
        check("to_latency_21_22", (d >= 21 && d <= 22), 1'b1);
        check("to_word_cnt", word_cnt, '0);
        check("to_frame_done", n_done, 1);
`else
        check("noto_out_words", out_data.size(), 4);
        check("noto_data", data_errors(4, 100), 0);
        check("noto_tlast_mask", last_mask(4), 64'h0);
        check("noto_word_cnt", word_cnt, LEN_W'(4));
        check("noto_word_held", s_if.tready, 1'b1);
        check("noto_m_tvalid", m_if.tvalid, 1'b0);
`endif

        // Single-word frames: nwords=1
        do_reset();
        nwords  = LEN_W'(1);
        timeout = '0;
        for (int i = 0; i < 3; i++) push_word(DATA_W'(32'hA0 + i));
        s_if.tvalid = 1'b0;
        step(4);
        check("one_out_words", out_data.size(), 3);
        check("one_data", data_errors(3, 32'hA0), 0);
        check("one_tlast_mask", last_mask(3), 64'h7);
        for (int i = 0; i < 3; i++) check("one_latency", out_cyc[i] - in_cyc[i], 2);
        check("one_frame_done", n_done, 3);

        // Backpressure: m_tready low for 10 cycles with H and O full
        do_reset();
        nwords = '0;
        for (int i = 0; i < 4; i++) push_word(DATA_W'(i));
        s_if.tvalid = 1'b0;
        #1;
        check("bp_ready_before", s_if.tready, 1'b1);
        m_if.tready = 1'b0;
        #1;
        check("bp_ready_dropped", s_if.tready, 1'b0);
        s_if.tdata  = DATA_W'(4);
        s_if.tvalid = 1'b1;
        n_ready     = 0;
        repeat (10) begin
            @(negedge clk);
            if (s_if.tready) n_ready++;
        end
        check("bp_ready_cycles", n_ready, 0);
        check("bp_o_held_valid", m_if.tvalid, 1'b1);
        check("bp_o_held_data", m_if.tdata, DATA_W'(2));
        check("bp_out_so_far", out_data.size(), 2);
        step(1);
        m_if.tready = 1'b1;
        for (int i = 4; i < 8; i++) push_word(DATA_W'(i));
        s_if.tvalid = 1'b0;
        step(3);
        check("bp_out_words", out_data.size(), 7);
        check("bp_data", data_errors(7, 0), 0);
        check("bp_tlast_mask", last_mask(7), 64'h0);
        check("bp_word_cnt", word_cnt, LEN_W'(7));

        // Clock enable freeze, then reset with two words buffered (cke low)
        do_reset();
        nwords      = LEN_W'(4);
        m_if.tready = 1'b0;
        push_word(DATA_W'(32'h50));
        push_word(DATA_W'(32'h51));
        s_if.tvalid = 1'b0;
        check("buf_word_cnt", word_cnt, LEN_W'(1));
        cke         = 1'b0;
        m_if.tready = 1'b1;
        step(3);
        check("cke_frozen_data", m_if.tdata, DATA_W'(32'h50));
        check("cke_frozen_valid", m_if.tvalid, 1'b1);
        check("cke_frozen_cnt", word_cnt, LEN_W'(1));
        m_if.tready = 1'b0;
        rst         = 1'b1;
        #1;
        check("rst_pulse_s_tready", s_if.tready, 1'b0);
        step(1);
        rst = 1'b0;
        cke = 1'b1;
        clear_log();
        check("rstp_m_tvalid", m_if.tvalid, 1'b0);
        check("rstp_m_tlast", m_if.tlast, 1'b0);
        check("rstp_m_tdata", m_if.tdata, '0);
        check("rstp_frame_done", frame_done, 1'b0);
        check("rstp_word_cnt", word_cnt, '0);
        m_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(DATA_W'(32'h60 + i));
        s_if.tvalid = 1'b0;
        step(4);
        check("rstp_out_words", out_data.size(), 4);
        check("rstp_data", data_errors(4, 32'h60), 0);
        check("rstp_tlast_mask", last_mask(4), 64'h8);
        check("rstp_frame_done_cnt", n_done, 1);

        // Loopback: 256 words into the sink with nwords=256
        do_reset();
        nwords = LEN_W'(256);
        for (int i = 0; i < 256; i++) push_word(DATA_W'(i));
        s_if.tvalid = 1'b0;
        step(5);
        n_last = 0;
        foreach (out_last[i]) if (out_last[i]) n_last++;
        check("lb_out_words", out_data.size(), 256);
        check("lb_data", data_errors(256, 0), 0);
        check("lb_tlast_count", n_last, 1);
        check("lb_tlast_pos", out_last[255], 1'b1);
        check("lb_frame_done", n_done, 1);
        check("lb_word_cnt", word_cnt, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
